// File: rtl/spart_pkg.sv
// Shared types for the spart receiver: rx state encoding and parity-sense constants.
// The PARITY state exists only when SPART_RX_PARITY_EN is defined.
package spart_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
`ifdef SPART_RX_PARITY_EN
    ST_PARITY   = 3'd3,
`endif
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

endpackage

// File: rtl/spart_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect on the
// synchronised output. All flops reset to the idle-high line level.
module spart_sync
  import spart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      rxd_s <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= rxd;
      rxd_s <= meta;
      prev  <= rxd_s;
    end
  end

  assign fall = prev & ~rxd_s;

endmodule

// File: rtl/spart_rx.sv
// Oversampling serial receiver with status flags and overrun detection.
// Optional parity check enabled by defining SPART_RX_PARITY_EN.
//
//   state     | meaning
//   IDLE      | line idle, waiting for falling edge
//   START     | confirming start bit at its centre
//   DATA      | sampling data bits at bit centres, LSB first
//   PARITY    | sampling parity bit (parity build only)
//   STOP      | sampling stop bit(s), accumulating frame error
//   BRK_WAIT  | errored frame ended with line low; wait for line high
module spart_rx
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 baud_tick,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BC_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    BC_STOP = 4'(STOP_BITS - 1);
`ifdef SPART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
`endif

  rx_state_t state, state_nxt;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 ferr_acc;
`ifdef SPART_RX_PARITY_EN
  logic                 perr_acc;
`endif
  logic                 load;
  logic                 rxd_s;
  logic                 fall;
  logic                 samp;

  spart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  // START samples half a bit in; every later sample is a full bit apart
  always_comb begin
    samp = baud_tick && (tick_cnt == ((state == ST_START) ? TC_HALF : TC_FULL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fall) state_nxt = ST_START;
      ST_START: if (samp) state_nxt = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (samp && bit_cnt == BC_DATA) begin
`ifdef SPART_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef SPART_RX_PARITY_EN
      ST_PARITY: if (samp) state_nxt = ST_STOP;
`endif
      ST_STOP: begin
        if (samp && bit_cnt == BC_STOP) state_nxt = rxd_s ? ST_IDLE : ST_BRK_WAIT;
      end
      ST_BRK_WAIT: if (baud_tick && rxd_s) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      ferr_acc <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      perr_acc <= 1'b0;
`endif
      load     <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            perr_acc <= 1'b0;
`endif
          end
        end
        ST_BRK_WAIT: ;
        default: begin
          if (baud_tick) begin
            if (!samp) begin
              tick_cnt <= tick_cnt + 1'b1;
            end else begin
              tick_cnt <= '0;
              case (state)
                ST_START: bit_cnt <= '0;
                ST_DATA: begin
                  shift   <= {rxd_s, shift[DATA_BITS-1:1]};
                  bit_cnt <= (bit_cnt == BC_DATA) ? 4'd0 : bit_cnt + 1'b1;
                end
`ifdef SPART_RX_PARITY_EN
                ST_PARITY: begin
                  perr_acc <= (^shift) ^ rxd_s ^ PAR_SENSE;
                  bit_cnt  <= '0;
                end
`endif
                ST_STOP: begin
                  ferr_acc <= ferr_acc | ~rxd_s;
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == BC_STOP) load <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  // A load always wins over a coincident rd_ack; overrun only on an unacknowledged overwrite
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rda        <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      rx_data   <= shift;
      frame_err <= ferr_acc;
`ifdef SPART_RX_PARITY_EN
      parity_err <= perr_acc;
`else
      parity_err <= 1'b0;
`endif
      rda <= 1'b1;
      if (rda && !rd_ack) overrun <= 1'b1;
      else if (rd_ack)    overrun <= 1'b0;
    end else if (rda && rd_ack) begin
      rda     <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL: parameter DATA_BITS, 8, data bits per frame (5..9).
REQ-002 SHALL: parameter OVERSAMPLE, 16, baud_tick pulses per bit period (even, 8..32).
REQ-003 SHALL: parameter STOP_BITS, 1, stop bits checked (1 or 2).
REQ-004 SHALL: parameter PARITY_ODD, 0, parity sense when parity is compiled in (0 even, 1 odd).
REQ-005 SHALL: clk  input  1  sole clock, rising edge.
REQ-006 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL: rxd  input  1  asynchronous serial line, idle high.
REQ-008 SHALL: baud_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-009 SHALL: rd_ack  input  1  consumer has taken rx_data.
REQ-010 SHALL: rx_data  output  DATA_BITS  last received word, LSB first on the line.
REQ-011 SHALL: rda  output  1  received data available.
REQ-012 SHALL: frame_err, parity_err, overrun  output  1 each  status of the word in rx_data.
REQ-013 SHALL: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL: rxd pass through two flops (reset value 1); all logic uses the second flop only.
REQ-015 SHALL: states IDLE, START, DATA, PARITY, STOP, BRK_WAIT; tick_cnt and bit_cnt advance only on baud_tick.
REQ-016 SHALL: IDLE -> START on synchronised 1->0 transition; tick_cnt cleared.
REQ-017 SHALL: START samples rxd at tick OVERSAMPLE/2; low -> DATA with counters cleared; high -> IDLE (false start, no flags).
REQ-018 SHALL: DATA samples every OVERSAMPLE ticks (bit centre), shifts LSB first, -> PARITY (if compiled) or STOP after DATA_BITS samples.
REQ-019 SHALL: STOP samples each stop bit at its centre; any low sample sets the frame's frame_err.
REQ-020 SHALL: one clk after last stop sample: rx_data, frame_err, parity_err loaded, rda=1; frame loaded even if errored.
REQ-021 SHALL: after a frame with frame_err and rxd still low, go BRK_WAIT and stay until rxd high, then IDLE (one frame per break).
REQ-022 SHALL: rd_ack with rda=1 clears rda and overrun next clk; rd_ack with rda=0 ignored.
REQ-023 SHALL: load while rda=1 and no rd_ack overwrites rx_data and sets overrun (sticky until rd_ack).
REQ-024 SHALL: load coincident with rd_ack: load wins, rda stays 1, overrun not set.
REQ-025 SHALL: baud_tick held low freezes the FSM and counters in place.

Reset
REQ-026 SHALL: rst_n low asynchronously forces state IDLE, counters 0, rx_data 0, rda/frame_err/parity_err/overrun/busy 0; mid-frame data discarded.

Configuration
REQ-027 SHALL: macro SPART_RX_PARITY_EN defined -> PARITY state samples one bit, parity_err set on mismatch with PARITY_ODD sense; undefined -> no PARITY state, parity_err tied 0, frame is start+DATA_BITS+STOP_BITS.

Structure
REQ-028 SHALL: package spart_pkg holds the rx state enum typedef and parity-sense constants.
REQ-029 SHALL: synchroniser and falling-edge detect in sub-module spart_sync.

Verification (DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1)
REQ-030 SHALL: 8N1 frame 0xA5 -> rda=1, rx_data=0xA5, all flags 0, 152 baud_ticks after edge detect.
REQ-031 SHALL: rxd low for 4 ticks then high -> no rda, busy returns 0.
REQ-032 SHALL: 0x3C with stop bit 0 then rxd held low 3 frame times -> exactly one rda with frame_err=1, busy until rxd high.
REQ-033 SHALL: 0x11 then 0x22 without rd_ack -> rx_data=0x22, overrun=1; rd_ack -> rda=0, overrun=0 next clk.
REQ-034 SHALL: SPART_RX_PARITY_EN, PARITY_ODD=0, 0x07 with parity bit 0 -> parity_err=1, rx_data=0x07.
REQ-035 SHALL: rst_n low during data bit 4 -> outputs 0 immediately; following frame 0x5A received clean.
